// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage hazard flags, load-use and MDU stall control with EX/MEM destination shadows
module hazard_detect #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] id_wreg,
  input  logic       id_rf_we,
  input  logic [2:0] id_rf_wsel,
  input  logic       id_mdu_op,
  input  logic       id_mdu_div,
  input  logic       id_hilo_access,
  input  logic       mem_stall,
  output logic       id_ex_hazard_mem,
  output logic       id_ex_rs_hazard_reg,
  output logic       id_ex_rt_hazard_reg,
  output logic       id_mem_rs_hazard_mem,
  output logic       id_mem_rt_hazard_mem,
  output logic       id_mem_rs_hazard_reg,
  output logic       id_mem_rt_hazard_reg,
  output logic       stall_pc,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       mdu_busy,
  output logic       mdu_done
);
  localparam logic [2:0] WSEL_RAM = 3'b011;
  localparam int CW = $clog2(DIV_CYCLES > MUL_CYCLES ? DIV_CYCLES : MUL_CYCLES) + 1;
  typedef enum logic {IDLE, BUSY} mdu_state_t;
  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wreg;
    logic [2:0] wsel;
  } shadow_t;
  shadow_t ex_q, ex_d, mem_q, mem_d;
  mdu_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ex_rs, ex_rt, mem_rs, mem_rt, ex_load, mem_load, mdu_stall, mdu_start;
  always_comb begin
    ex_rs = id_valid & id_rs_used & ex_q.v & ex_q.we & (ex_q.wreg != 5'd0) & (ex_q.wreg == id_rs);
    ex_rt = id_valid & id_rt_used & ex_q.v & ex_q.we & (ex_q.wreg != 5'd0) & (ex_q.wreg == id_rt);
    mem_rs = id_valid & id_rs_used & mem_q.v & mem_q.we & (mem_q.wreg != 5'd0) & (mem_q.wreg == id_rs);
    mem_rt = id_valid & id_rt_used & mem_q.v & mem_q.we & (mem_q.wreg != 5'd0) & (mem_q.wreg == id_rt);
    ex_load = ex_q.wsel == WSEL_RAM;
    mem_load = mem_q.wsel == WSEL_RAM;
    id_ex_hazard_mem = (ex_rs | ex_rt) & ex_load;
    id_ex_rs_hazard_reg = ex_rs & ~ex_load;
    id_ex_rt_hazard_reg = ex_rt & ~ex_load;
    id_mem_rs_hazard_mem = mem_rs & ~ex_rs & mem_load;
    id_mem_rt_hazard_mem = mem_rt & ~ex_rt & mem_load;
    id_mem_rs_hazard_reg = mem_rs & ~ex_rs & ~mem_load;
    id_mem_rt_hazard_reg = mem_rt & ~ex_rt & ~mem_load;
    mdu_busy = state_q == BUSY;
    mdu_done = mdu_busy & (cnt_q == '0);
    mdu_stall = mdu_busy & ~mdu_done & id_valid & id_hilo_access;
    stall_pc = mem_stall | id_ex_hazard_mem | mdu_stall;
    stall_id = stall_pc;
    bubble_ex = (id_ex_hazard_mem | mdu_stall) & ~mem_stall;
    mem_d = mem_stall ? mem_q : ex_q;
    ex_d = mem_stall ? ex_q : bubble_ex ? '0 : {id_valid, id_rf_we, id_wreg, id_rf_wsel};
    mdu_start = ~mdu_busy & id_valid & id_mdu_op & ~stall_id;
    state_d = mdu_busy ? (mdu_done ? IDLE : BUSY) : (mdu_start ? BUSY : IDLE);
    cnt_d = mdu_start ? (id_mdu_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1)) :
            mdu_busy & ~mdu_done ? cnt_q - CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed and randomized checks of hazard_detect against a pipeline-slot reference model
module tb_hazard_detect;
  localparam int MUL = 2;
  localparam int DIV = 32;
  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wreg;
    logic [2:0] wsel;
  } slot_t;
  logic clk = 0, rst = 1;
  logic id_valid, id_rs_used, id_rt_used, id_rf_we, id_mdu_op, id_mdu_div, id_hilo_access, mem_stall;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic [2:0] id_rf_wsel;
  logic id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
  logic id_mem_rs_hazard_mem, id_mem_rt_hazard_mem, id_mem_rs_hazard_reg, id_mem_rt_hazard_reg;
  logic stall_pc, stall_id, bubble_ex, mdu_busy, mdu_done;
  logic [11:0] outs, exp;
  slot_t m_ex = '0, m_mem = '0;
  int busy_left = 0;
  int total = 0, bad = 0;
  hazard_detect #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_rf_we(id_rf_we),
    .id_rf_wsel(id_rf_wsel), .id_mdu_op(id_mdu_op), .id_mdu_div(id_mdu_div),
    .id_hilo_access(id_hilo_access), .mem_stall(mem_stall),
    .id_ex_hazard_mem(id_ex_hazard_mem), .id_ex_rs_hazard_reg(id_ex_rs_hazard_reg),
    .id_ex_rt_hazard_reg(id_ex_rt_hazard_reg), .id_mem_rs_hazard_mem(id_mem_rs_hazard_mem),
    .id_mem_rt_hazard_mem(id_mem_rt_hazard_mem), .id_mem_rs_hazard_reg(id_mem_rs_hazard_reg),
    .id_mem_rt_hazard_reg(id_mem_rt_hazard_reg), .stall_pc(stall_pc), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );
  always #5 clk = ~clk;
  assign outs = {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg, id_mem_rs_hazard_mem,
                 id_mem_rt_hazard_mem, id_mem_rs_hazard_reg, id_mem_rt_hazard_reg, stall_pc, stall_id,
                 bubble_ex, mdu_busy, mdu_done};
  function automatic logic reads(slot_t s, logic [4:0] r, logic used);
    return id_valid && used && s.v && s.we && r != 5'd0 && s.wreg == r;
  endfunction
  function automatic logic [11:0] model_out();
    logic ers, ert, mrs, mrt, el, ml, hz, busy, done, ms, st;
    ers = reads(m_ex, id_rs, id_rs_used);
    ert = reads(m_ex, id_rt, id_rt_used);
    mrs = reads(m_mem, id_rs, id_rs_used);
    mrt = reads(m_mem, id_rt, id_rt_used);
    el = m_ex.wsel == 3'd3;
    ml = m_mem.wsel == 3'd3;
    hz = (ers || ert) && el;
    busy = busy_left != 0;
    done = busy_left == 1;
    ms = busy && !done && id_valid && id_hilo_access;
    st = mem_stall || hz || ms;
    return {hz, ers && !el, ert && !el, mrs && !ers && ml, mrt && !ert && ml, mrs && !ers && !ml,
            mrt && !ert && !ml, st, st, (hz || ms) && !mem_stall, busy, done};
  endfunction
  task automatic model_clear();
    m_ex = '0;
    m_mem = '0;
    busy_left = 0;
  endtask
  task automatic model_step();
    logic [11:0] o;
    o = model_out();
    if (rst) begin
      model_clear();
    end else begin
      if (!mem_stall) begin
        m_mem = m_ex;
        m_ex = o[2] ? '0 : {id_valid, id_rf_we, id_wreg, id_rf_wsel};
      end
      if (busy_left != 0) busy_left--;
      else if (id_valid && id_mdu_op && !o[3]) busy_left = id_mdu_div ? DIV : MUL;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic [4:0] wr, input logic we, input logic [2:0] ws,
                        input logic mdu, input logic dv, input logic hl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_wreg = wr; id_rf_we = we; id_rf_wsel = ws; id_mdu_op = mdu; id_mdu_div = dv; id_hilo_access = hl;
  endtask
  task automatic pulse_reset();
    rst = 1;
    model_clear();
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    set_id(1, 5, 6, 1, 1, 7, 1, 3'd3, 1, 1, 1);
    mem_stall = 0;
    rst = 1;
    model_clear();
    @(negedge clk);
    total++; if (outs !== 12'd0) begin bad++; $display("FAIL reset_hold got=%b want=%b", outs, 12'd0); end
    tick();
    rst = 0;
    @(negedge clk);
    total++; if (outs !== 12'd0) begin bad++; $display("FAIL reset_first got=%b want=%b", outs, 12'd0); end
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL reset_model got=%b want=%b", outs, exp); end
    tick();
  endtask
  task automatic test_load_use();
    pulse_reset();
    set_id(1, 2, 0, 1, 0, 5, 1, 3'd3, 0, 0, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 3'd1, 0, 0, 0);
    @(negedge clk);
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL lu_c1_model got=%b want=%b", outs, exp); end
    total++; if (outs !== 12'b100000011100) begin bad++; $display("FAIL lu_c1 got=%b want=%b", outs, 12'b100000011100); end
    tick();
    @(negedge clk);
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL lu_c2_model got=%b want=%b", outs, exp); end
    total++; if (outs !== 12'b000100000000) begin bad++; $display("FAIL lu_c2 got=%b want=%b", outs, 12'b000100000000); end
    tick();
  endtask
  task automatic test_alu_fwd();
    pulse_reset();
    set_id(1, 1, 2, 1, 1, 3, 1, 3'd1, 0, 0, 0);
    tick();
    set_id(1, 3, 3, 1, 1, 0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL alu_ex_model got=%b want=%b", outs, exp); end
    total++; if (outs !== 12'b011000000000) begin bad++; $display("FAIL alu_ex got=%b want=%b", outs, 12'b011000000000); end
    set_id(1, 1, 2, 1, 1, 3, 1, 3'd1, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    tick();
    set_id(1, 3, 3, 1, 1, 0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL alu_mem_model got=%b want=%b", outs, exp); end
    total++; if (outs !== 12'b000001100000) begin bad++; $display("FAIL alu_mem got=%b want=%b", outs, 12'b000001100000); end
    tick();
  endtask
  task automatic test_zero_reg();
    pulse_reset();
    set_id(1, 1, 2, 1, 1, 0, 1, 3'd3, 0, 0, 0);
    tick();
    set_id(1, 1, 2, 1, 1, 0, 1, 3'd1, 0, 0, 0);
    tick();
    set_id(1, 0, 0, 1, 1, 9, 1, 3'd1, 0, 0, 0);
    @(negedge clk);
    total++; if (outs !== 12'd0) begin bad++; $display("FAIL zero_reg got=%b want=%b", outs, 12'd0); end
    tick();
  endtask
  task automatic test_priority();
    pulse_reset();
    set_id(1, 1, 2, 1, 1, 4, 1, 3'd1, 0, 0, 0);
    tick();
    tick();
    set_id(1, 4, 7, 1, 1, 8, 1, 3'd1, 0, 0, 0);
    @(negedge clk);
    exp = model_out();
    total++; if (outs !== exp) begin bad++; $display("FAIL prio_alu_model got=%b want=%b", outs, exp); end
    total++; if (outs !== 12'b010000000000) begin bad++; $display("FAIL prio_alu got=%b want=%b", outs, 12'b010000000000); end
    pulse_reset();
    set_id(1, 1, 2, 1, 1, 4, 1, 3'd3, 0, 0, 0);
    tick();
    set_id(1, 1, 2, 1, 1, 4, 1, 3'd1, 0, 0, 0);
    tick();
    set_id(1, 4, 7, 1, 1, 8, 1, 3'd1, 0, 0, 0);
    @(negedge clk);
    total++; if (outs !== 12'b010000000000) begin bad++; $display("FAIL prio_load got=%b want=%b", outs, 12'b010000000000); end
    tick();
  endtask
  task automatic test_mdu();
    int busy_n = 0, stall_n = 0;
    logic done_seen = 0;
    pulse_reset();
    set_id(1, 1, 2, 1, 1, 0, 0, 3'd0, 1, 1, 1);
    tick();
    set_id(1, 0, 0, 0, 0, 2, 1, 3'd5, 0, 0, 1);
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge clk);
      exp = model_out();
      total++; if (outs !== exp) begin bad++; $display("FAIL mdu_cyc%0d got=%b want=%b", i, outs, exp); end
      busy_n += int'(mdu_busy);
      stall_n += int'(stall_id);
      done_seen = mdu_done;
      tick();
    end
    total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL mdu_timeout got=%b want=1", done_seen); end
    total++; if (busy_n != DIV) begin bad++; $display("FAIL mdu_busy_cycles got=%0d want=%0d", busy_n, DIV); end
    total++; if (stall_n != DIV - 1) begin bad++; $display("FAIL mdu_stall_cycles got=%0d want=%0d", stall_n, DIV - 1); end
    set_id(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    @(negedge clk);
    total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL mdu_idle got=%b want=0", mdu_busy); end
    tick();
  endtask
  task automatic test_mem_stall();
    int bubbles = 0;
    pulse_reset();
    set_id(1, 2, 0, 1, 0, 5, 1, 3'd3, 0, 0, 0);
    tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 3'd1, 0, 0, 0);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (outs !== 12'b100000011000) begin bad++; $display("FAIL ms_hold%0d got=%b want=%b", i, outs, 12'b100000011000); end
      tick();
    end
    mem_stall = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = model_out();
      total++; if (outs !== exp) begin bad++; $display("FAIL ms_rel%0d got=%b want=%b", i, outs, exp); end
      bubbles += int'(bubble_ex);
      tick();
    end
    total++; if (bubbles != 1) begin bad++; $display("FAIL ms_bubbles got=%0d want=1", bubbles); end
    set_id(1, 1, 2, 1, 1, 0, 0, 3'd0, 1, 1, 1);
    tick();
    set_id(1, 0, 0, 0, 0, 2, 1, 3'd5, 0, 0, 1);
    @(negedge clk);
    total++; if (mdu_busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", mdu_busy); end
    rst = 1;
    model_clear();
    #1;
    total++; if (outs !== 12'd0) begin bad++; $display("FAIL rst_mid got=%b want=%b", outs, 12'd0); end
    tick();
    rst = 0;
    @(negedge clk);
    total++; if (outs !== 12'd0) begin bad++; $display("FAIL rst_after got=%b want=%b", outs, 12'd0); end
    tick();
  endtask
  task automatic test_random();
    logic [2:0] wsels [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic mdu;
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      mdu = $urandom_range(0, 15) == 0;
      set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             wsels[$urandom_range(0, 5)], mdu, 1'($urandom), mdu | ($urandom_range(0, 3) == 0));
      mem_stall = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 199) == 0;
      if (rst) model_clear();
      @(negedge clk);
      exp = model_out();
      total++; if (outs !== exp) begin bad++; $display("FAIL rand_cyc%0d got=%b want=%b", i, outs, exp); end
      tick();
    end
    rst = 0;
    mem_stall = 0;
  endtask
  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    mem_stall = 0;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_zero_reg();
    test_priority();
    test_mdu();
    test_mem_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
